hazard_controller: RTL and testbench

Sequencing controller for the five-stage 8-bit pipeline: it decides every cycle whether the PC and the IF/ID register advance, and whether IF/ID or ID/EX is squashed. It handles load-use stalls (ID source register matches a load in EX) and control redirects from decode (branch, jump, call: one bubble; return: two bubbles, because the stack pop is registered). It replaces the ad-hoc stall wiring from the forwarding unit and keeps saturating stall and flush cycle counters for bring-up.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_controller.sv | 89 ++++++++
 tb/tb_hazard_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the five-stage 8-bit pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int          REG_ADDR_W = 3;
    localparam logic [18:0] NOP_INSTR  = 19'b0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_controller_if.sv
// ============================================================================
// Module      : hazard_controller_if
// Description : Pipeline-side hazard inputs and sequencing/counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_controller_if
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_ADDR_W-1:0] idR1Address;
    logic [REG_ADDR_W-1:0] idR2Address;
    logic                  idUsesR1;
    logic                  idUsesR2;
    logic [REG_ADDR_W-1:0] exDest;
    logic                  exRegWrite;
    logic                  exRegWriteDataSel;
    logic                  idRedirect;
    logic                  idIsRet;
    logic                  pcEnb;
    logic                  ifIdEnb;
    logic                  ifIdFlush;
    logic                  idExFlush;
    logic [CNT_W-1:0]      stallCount;
    logic [CNT_W-1:0]      flushCount;

    modport master (
        output idR1Address, idR2Address, idUsesR1, idUsesR2,
               exDest, exRegWrite, exRegWriteDataSel, idRedirect, idIsRet,
        input  pcEnb, ifIdEnb, ifIdFlush, idExFlush, stallCount, flushCount
    );

    modport slave (
        input  idR1Address, idR2Address, idUsesR1, idUsesR2,
               exDest, exRegWrite, exRegWriteDataSel, idRedirect, idIsRet,
        output pcEnb, ifIdEnb, ifIdFlush, idExFlush, stallCount, flushCount
    );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic      [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module      : hazard_controller
// Description : Load-use stall and redirect squash sequencing, with counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hazard_controller_if.slave hz
);
    import pipeline_pkg::*;

    state_t r_state;
    state_t w_state_next;
    logic   w_load_use;
    logic   w_stall_inc;
    logic   w_flush_inc;

    // r0 is an ordinary register here, so address 0 matches like any other.
    assign w_load_use = hz.exRegWrite & hz.exRegWriteDataSel &
                        ((hz.idUsesR1 & (hz.idR1Address == hz.exDest)) |
                         (hz.idUsesR2 & (hz.idR2Address == hz.exDest)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        hz.pcEnb     = 1'b1;
        hz.ifIdEnb   = 1'b1;
        hz.ifIdFlush = 1'b0;
        hz.idExFlush = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (w_load_use) begin
                        // Hold PC and the ID instruction; any redirect is re-seen next cycle.
                        hz.pcEnb     = 1'b0;
                        hz.ifIdEnb   = 1'b0;
                        hz.idExFlush = 1'b1;
                        w_stall_inc  = 1'b1;
                    end else if (hz.idRedirect) begin
                        hz.ifIdFlush = 1'b1;
                        w_flush_inc  = 1'b1;
                        // Returns need one more bubble: the stack pop lands a cycle late.
                        w_state_next = hz.idIsRet ? FLUSH1 : RUN;
                    end
                end
                FLUSH1: begin
                    hz.ifIdFlush = 1'b1;
                    w_flush_inc  = 1'b1;
                    w_state_next = RUN;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (hz.stallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (hz.flushCount)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus random traffic against a
// bubble-budget model; a 2-bit-counter instance shares the stimulus.
`default_nettype none

module tb_hazard_controller;

    typedef struct packed {
        logic       rst;
        logic [2:0] r1;
        logic [2:0] r2;
        logic       u1;
        logic       u2;
        logic [2:0] dst;
        logic       rw;
        logic       ds;
        logic       redir;
        logic       ret;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // model: squash cycles still owed, and unbounded event counts since reset
    int   pend  = 0;
    int   n_st  = 0;
    int   n_fl  = 0;
    bit   cnt_valid = 1'b0;

    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(16)) hif ();
    hazard_controller_if #(.CNT_W(2))  hif_s ();

    assign hif_s.idR1Address       = hif.idR1Address;
    assign hif_s.idR2Address       = hif.idR2Address;
    assign hif_s.idUsesR1          = hif.idUsesR1;
    assign hif_s.idUsesR2          = hif.idUsesR2;
    assign hif_s.exDest            = hif.exDest;
    assign hif_s.exRegWrite        = hif.exRegWrite;
    assign hif_s.exRegWriteDataSel = hif.exRegWriteDataSel;
    assign hif_s.idRedirect        = hif.idRedirect;
    assign hif_s.idIsRet           = hif.idIsRet;

    hazard_controller #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    hazard_controller #(.CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .hz  (hif_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Drive one cycle, compare against the model, then advance the model past the edge.
    task automatic step(input stim_t s);
        bit lu;
        int e_pc, e_ifid, e_iff, e_idf;
        @(negedge clk);
        rst                        = s.rst;
        hif.idR1Address            = s.r1;
        hif.idR2Address            = s.r2;
        hif.idUsesR1               = s.u1;
        hif.idUsesR2               = s.u2;
        hif.exDest                 = s.dst;
        hif.exRegWrite             = s.rw;
        hif.exRegWriteDataSel      = s.ds;
        hif.idRedirect             = s.redir;
        hif.idIsRet                = s.ret;
        #1;
        lu = s.rw && s.ds && ((s.u1 && s.r1 == s.dst) || (s.u2 && s.r2 == s.dst));
        e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0;
        if (s.rst) begin
        end else if (pend > 0) begin
            e_iff = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_idf = 1;
        end else if (s.redir) begin
            e_iff = 1;
        end
        chk("pcEnb",     32'(hif.pcEnb),     32'(e_pc));
        chk("ifIdEnb",   32'(hif.ifIdEnb),   32'(e_ifid));
        chk("ifIdFlush", 32'(hif.ifIdFlush), 32'(e_iff));
        chk("idExFlush", 32'(hif.idExFlush), 32'(e_idf));
        chk("s_ifIdFlush", 32'(hif_s.ifIdFlush), 32'(e_iff));
        if (cnt_valid) begin
            chk("stallCount",   32'(hif.stallCount),   32'(sat(n_st, 65535)));
            chk("flushCount",   32'(hif.flushCount),   32'(sat(n_fl, 65535)));
            chk("s_stallCount", 32'(hif_s.stallCount), 32'(sat(n_st, 3)));
            chk("s_flushCount", 32'(hif_s.flushCount), 32'(sat(n_fl, 3)));
        end
        if (s.rst) begin
            pend = 0; n_st = 0; n_fl = 0; cnt_valid = 1'b1;
        end else if (pend > 0) begin
            n_fl++; pend--;
        end else if (lu) begin
            n_st++;
        end else if (s.redir) begin
            n_fl++;
            pend = s.ret ? 1 : 0;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t load_use(input logic [2:0] dst);
        stim_t s;
        s = '0;
        s.rw = 1'b1; s.ds = 1'b1; s.dst = dst; s.u1 = 1'b1; s.r1 = 3'd3;
        return s;
    endfunction

    function automatic stim_t redirect(input logic ret);
        stim_t s;
        s = '0;
        s.redir = 1'b1; s.ret = ret;
        return s;
    endfunction

    initial begin
        stim_t s;

        s = load_use(3'd3); s.rst = 1'b1;
        step(s);
        chk("rst_forces_pcEnb", 32'(hif.pcEnb), 32'd1);
        chk("rst_forces_idExFlush", 32'(hif.idExFlush), 32'd0);
        step(s);
        step(idle());
        chk("reset_stallCount", 32'(hif.stallCount), 32'd0);
        chk("reset_flushCount", 32'(hif.flushCount), 32'd0);

        // load-use on R1
        step(load_use(3'd3));
        chk("lu_pcEnb", 32'(hif.pcEnb), 32'd0);
        chk("lu_ifIdEnb", 32'(hif.ifIdEnb), 32'd0);
        chk("lu_idExFlush", 32'(hif.idExFlush), 32'd1);
        step(idle());
        chk("lu_stallCount", 32'(hif.stallCount), 32'd1);
        chk("lu_released", 32'(hif.pcEnb), 32'd1);

        step(load_use(3'd4));
        chk("nolu_pcEnb", 32'(hif.pcEnb), 32'd1);
        s = load_use(3'd3); s.ds = 1'b0;
        step(s);
        chk("alu_idExFlush", 32'(hif.idExFlush), 32'd0);
        // r0 still stalls through R2
        s = idle(); s.rw = 1'b1; s.ds = 1'b1; s.dst = 3'd0; s.u2 = 1'b1; s.r2 = 3'd0;
        step(s);
        chk("r0_idExFlush", 32'(hif.idExFlush), 32'd1);
        step(idle());
        chk("r0_stallCount", 32'(hif.stallCount), 32'd2);

        // jump
        step(redirect(1'b0));
        chk("jmp_ifIdFlush", 32'(hif.ifIdFlush), 32'd1);
        step(idle());
        chk("jmp_done", 32'(hif.ifIdFlush), 32'd0);
        chk("jmp_flushCount", 32'(hif.flushCount), 32'd1);

        // return: second bubble ignores a redirect in ID
        step(redirect(1'b1));
        chk("ret_flush_a", 32'(hif.ifIdFlush), 32'd1);
        step(redirect(1'b0));
        chk("ret_flush_b", 32'(hif.ifIdFlush), 32'd1);
        step(idle());
        chk("ret_done", 32'(hif.ifIdFlush), 32'd0);
        chk("ret_flushCount", 32'(hif.flushCount), 32'd3);

        // simultaneous load-use and redirect
        s = load_use(3'd3); s.redir = 1'b1;
        step(s);
        chk("sim_idExFlush", 32'(hif.idExFlush), 32'd1);
        chk("sim_ifIdFlush", 32'(hif.ifIdFlush), 32'd0);
        step(redirect(1'b0));
        chk("sim_then_flush", 32'(hif.ifIdFlush), 32'd1);

        // reset while in FLUSH1
        step(redirect(1'b1));
        s = redirect(1'b0); s.rst = 1'b1;
        step(s);
        chk("rst_in_flush1", 32'(hif.ifIdFlush), 32'd0);
        step(idle());
        chk("post_rst_flush", 32'(hif.ifIdFlush), 32'd0);
        chk("post_rst_stall", 32'(hif.stallCount), 32'd0);
        chk("post_rst_fcnt", 32'(hif.flushCount), 32'd0);

        // saturation of the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            step(load_use(3'd3));
            step(idle());
        end
        step(idle());
        chk("sat_small", 32'(hif_s.stallCount), 32'd3);
        chk("sat_wide", 32'(hif.stallCount), 32'd4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(0, 63) == 0);
            s.r1    = 3'($urandom_range(0, 7));
            s.r2    = 3'($urandom_range(0, 7));
            s.u1    = 1'($urandom);
            s.u2    = 1'($urandom);
            s.dst   = 3'($urandom_range(0, 7));
            s.rw    = ($urandom_range(0, 3) != 0);
            s.ds    = ($urandom_range(0, 2) != 0);
            s.redir = ($urandom_range(0, 3) == 0);
            s.ret   = 1'($urandom);
            step(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
